// File: rtl/regfile_32x32_pkg.sv
// Shared sizing constants and helpers for the 32x32 architectural register file.
package regfile_32x32_pkg;

    localparam int                    NUM_REGS   = 32;
    localparam int                    REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG   = 5'd0;

    function automatic logic is_zero_reg(input logic [REG_ADDR_W-1:0] addr);
        return addr == ZERO_REG;
    endfunction

endpackage

// File: rtl/regfile_32x32_decoder.sv
// 5-to-32 one-hot write-address decoder; each line selects one register's load enable.
module decoder_5_32
    import regfile_32x32_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] i_addr,
    output logic [NUM_REGS-1:0]   o_onehot
);

    always_comb begin
        o_onehot         = '0;
        o_onehot[i_addr] = 1'b1;
    end

endmodule

// File: rtl/regfile_32x32_register.sv
// WIDTH-bit storage register with asynchronous active-low clear and load enable.
module register_w #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/regfile_32x32.sv
// 32x32 register file: one synchronous write port, two combinational read ports,
// hardwired zero register and optional same-cycle write-to-read bypass.
module regfile_32x32
    import regfile_32x32_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter bit BYPASS = 1'b1
) (
    input  logic                  clock,
    input  logic                  ctrl_reset_n,
    input  logic                  ctrl_writeEnable,
    input  logic [REG_ADDR_W-1:0] ctrl_writeReg,
    input  logic [WIDTH-1:0]      data_writeReg,
    input  logic [REG_ADDR_W-1:0] ctrl_readRegA,
    input  logic [REG_ADDR_W-1:0] ctrl_readRegB,
    output logic [WIDTH-1:0]      data_readRegA,
    output logic [WIDTH-1:0]      data_readRegB
);

    logic [NUM_REGS-1:0] w_dec;
    logic [NUM_REGS-1:0] w_load;
    logic [WIDTH-1:0]    w_regs [NUM_REGS];
    logic                w_byp_a;
    logic                w_byp_b;

    decoder_5_32 u_dec (
        .i_addr   (ctrl_writeReg),
        .o_onehot (w_dec)
    );

    assign w_load = w_dec & {NUM_REGS{ctrl_writeEnable}};

    // Register 0 has no storage; its load line only feeds the bypass lookup.
    assign w_regs[0] = '0;

    generate
        for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_reg
            register_w #(.WIDTH(WIDTH)) u_reg (
                .i_clk   (clock),
                .i_rst_n (ctrl_reset_n),
                .i_load  (w_load[gi]),
                .i_d     (data_writeReg),
                .o_q     (w_regs[gi])
            );
        end
    endgenerate

    // The one-hot load vector indexed by the read address is the address-match
    // compare; reset suppresses forwarding so outputs drop to zero immediately.
    assign w_byp_a = BYPASS && ctrl_reset_n && w_load[ctrl_readRegA] &&
                     !is_zero_reg(ctrl_readRegA);
    assign w_byp_b = BYPASS && ctrl_reset_n && w_load[ctrl_readRegB] &&
                     !is_zero_reg(ctrl_readRegB);

    always_comb begin
        data_readRegA = w_byp_a ? data_writeReg : w_regs[ctrl_readRegA];
        data_readRegB = w_byp_b ? data_writeReg : w_regs[ctrl_readRegB];
    end

endmodule

// File: tb/tb_regfile_32x32.sv
// Scoreboard bench: drives both BYPASS variants in parallel from the same inputs.
module tb_regfile_32x32;

    logic        clock = 1'b0;
    logic        rst_n;
    logic        we;
    logic [4:0]  wa, ra, rb;
    logic [31:0] wd;
    logic [31:0] a1, b1, a0, b0;

    typedef struct {
        string       name;
        logic [31:0] a1, b1, a0, b0;
    } exp_t;

    exp_t        sb[$];
    event        sample_ev;
    int          total = 0;
    int          bad   = 0;
    logic [31:0] mdl [32];

    always #5 clock = ~clock;

    regfile_32x32 #(.WIDTH(32), .BYPASS(1'b1)) dut_byp (
        .clock(clock), .ctrl_reset_n(rst_n), .ctrl_writeEnable(we),
        .ctrl_writeReg(wa), .data_writeReg(wd),
        .ctrl_readRegA(ra), .ctrl_readRegB(rb),
        .data_readRegA(a1), .data_readRegB(b1)
    );

    regfile_32x32 #(.WIDTH(32), .BYPASS(1'b0)) dut_nobyp (
        .clock(clock), .ctrl_reset_n(rst_n), .ctrl_writeEnable(we),
        .ctrl_writeReg(wa), .data_writeReg(wd),
        .ctrl_readRegA(ra), .ctrl_readRegB(rb),
        .data_readRegA(a0), .data_readRegB(b0)
    );

    task automatic cmp(input string name, input string port,
                       input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s %s: got %08h want %08h", name, port, act, exp);
        end
    endtask

    // Monitor: pops every pending expectation when the outputs are sampled.
    initial begin
        exp_t e;
        forever begin
            @(sample_ev);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                cmp(e.name, "A/byp",   a1, e.a1);
                cmp(e.name, "B/byp",   b1, e.b1);
                cmp(e.name, "A/nobyp", a0, e.a0);
                cmp(e.name, "B/nobyp", b0, e.b0);
            end
        end
    end

    task automatic chk4(input string name, input logic [31:0] ea1, input logic [31:0] eb1,
                        input logic [31:0] ea0, input logic [31:0] eb0);
        exp_t e;
        e.name = name; e.a1 = ea1; e.b1 = eb1; e.a0 = ea0; e.b0 = eb0;
        sb.push_back(e);
        #1 -> sample_ev;
        #1;
    endtask

    task automatic rd(input string name, input logic [4:0] addr_a, input logic [4:0] addr_b);
        ra = addr_a;
        rb = addr_b;
        chk4(name, mdl[addr_a], mdl[addr_b], mdl[addr_a], mdl[addr_b]);
    endtask

    task automatic wr(input logic [4:0] addr, input logic [31:0] data);
        @(negedge clock);
        we = 1'b1; wa = addr; wd = data;
        @(posedge clock);
        #1;
        we = 1'b0; wd = '0;
        if (rst_n && addr != 5'd0) mdl[addr] = data;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mdl[i] = '0;
        rst_n = 1'b0; we = 1'b0; wa = '0; wd = '0; ra = 5'd1; rb = 5'd31;
        #1;
        chk4("reset_state", 32'h0, 32'h0, 32'h0, 32'h0);
        @(negedge clock);
        rst_n = 1'b1;

        // Sweep write then read every address, B walking the other way.
        for (int i = 1; i < 32; i++) wr(5'(i), 32'hA5A5_0000 + 32'(i));
        for (int i = 0; i < 32; i++) rd("sweep", 5'(i), 5'(31 - i));

        // Register 0: write ignored, bypass on address 0 suppressed.
        @(negedge clock);
        we = 1'b1; wa = 5'd0; wd = 32'hFFFF_FFFF; ra = 5'd0; rb = 5'd1;
        chk4("r0_byp", 32'h0, 32'hA5A5_0001, 32'h0, 32'hA5A5_0001);
        @(posedge clock); #1; we = 1'b0;
        rd("r0_after", 5'd0, 5'd0);
        rd("r0_others", 5'd1, 5'd31);

        // Same-cycle bypass on both ports vs. pre-write value.
        @(negedge clock);
        we = 1'b1; wa = 5'd7; wd = 32'h1234_5678; ra = 5'd7; rb = 5'd7;
        chk4("byp_pre", 32'h1234_5678, 32'h1234_5678, 32'hA5A5_0007, 32'hA5A5_0007);
        @(posedge clock); #1; we = 1'b0; mdl[7] = 32'h1234_5678;
        rd("byp_post", 5'd7, 5'd7);

        // Independent ports: only B matches the write address.
        @(negedge clock);
        we = 1'b1; wa = 5'd8; wd = 32'h0BAD_F00D; ra = 5'd7; rb = 5'd8;
        chk4("byp_split", 32'h1234_5678, 32'h0BAD_F00D, 32'h1234_5678, 32'hA5A5_0008);
        @(posedge clock); #1; we = 1'b0; mdl[8] = 32'h0BAD_F00D;
        rd("split_post", 5'd8, 5'd9);

        // Disabled writes, including X data.
        @(negedge clock);
        we = 1'b0; wa = 5'd5; wd = 32'hDEAD_BEEF; ra = 5'd5; rb = 5'd5;
        @(posedge clock); #1;
        wd = 'x;
        @(posedge clock); #1;
        rd("we_off", 5'd5, 5'd6);

        // Back-to-back writes to one address: last wins.
        wr(5'd9, 32'h0000_0111);
        wr(5'd9, 32'h0000_0222);
        rd("b2b", 5'd9, 5'd10);

        // Mid-cycle asynchronous reset.
        wr(5'd3, 32'h0000_0001);
        rd("pre_rst", 5'd3, 5'd31);
        @(negedge clock);
        ra = 5'd3; rb = 5'd31;
        rst_n = 1'b0;
        for (int i = 0; i < 32; i++) mdl[i] = '0;
        chk4("async_rst", 32'h0, 32'h0, 32'h0, 32'h0);
        we = 1'b1; wa = 5'd4; wd = 32'h0000_0055; ra = 5'd4; rb = 5'd3;
        chk4("rst_byp", 32'h0, 32'h0, 32'h0, 32'h0);
        @(posedge clock); #1; we = 1'b0;
        for (int i = 0; i < 32; i++) rd("rst_sweep", 5'(i), 5'(31 - i));
        @(negedge clock);
        rst_n = 1'b1;
        wr(5'd3, 32'h0000_0002);
        rd("post_rst", 5'd3, 5'd4);

        #20;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
